// File: rtl/fft_bfly_scheduler.sv
// fft_bfly_scheduler: radix-2 in-place FFT butterfly address/twiddle sequencer.
// Issues N/2 butterflies per stage over N_LOG2 stages. A barrier between
// stages waits for every write-back of the previous stage before the next
// stage issues. All outputs are registered.
// Optional feature: define FFT_BFLY_SCALE_EN to raise bf_scale alongside every
// bf_valid, which asks the datapath for a 1/2 scaling on each stage. When it is
// undefined, bf_scale is tied low.
module fft_bfly_scheduler #(
  parameter int N_LOG2 = 3
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  output logic                        busy,
  output logic                        done,
  output logic                        bf_valid,
  input  logic                        bf_ready,
  output logic [N_LOG2-1:0]           addr_a,
  output logic [N_LOG2-1:0]           addr_b,
  output logic [N_LOG2-2:0]           tw_idx,
  output logic [$clog2(N_LOG2+1)-1:0] stage,
  output logic                        bf_scale,
  input  logic                        wb_valid,
  output logic                        err
);

  localparam int AW = N_LOG2;
  localparam int KW = N_LOG2 - 1;
  localparam int SW = $clog2(N_LOG2 + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  localparam logic [KW-1:0] K_LAST     = {KW{1'b1}};
  localparam logic [KW-1:0] K_ONE      = KW'(1);
  localparam logic [SW-1:0] STAGE_LAST = SW'(N_LOG2 - 1);
  localparam logic [SW-1:0] S_ONE      = SW'(1);
  localparam logic [AW-1:0] A_ONE      = AW'(1);

  logic [1:0]    state_q, state_d;
  logic [KW-1:0] k_q, k_d;
  logic [SW-1:0] stage_q, stage_d;
  logic [AW-1:0] outstanding_q, outstanding_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          valid_q, valid_d;
  logic          scale_q, scale_d;
  logic          err_q, err_d;
  logic [AW-1:0] addr_a_q, addr_a_d;
  logic [AW-1:0] addr_b_q, addr_b_d;
  logic [KW-1:0] tw_q, tw_d;

  logic          accept_s;
  logic          wb_dec_s;
  logic [AW-1:0] k_ext_s, half_s, mask_s, pos_s, a_s, b_s;
  logic [KW-1:0] t_s;

  assign accept_s = valid_q & bf_ready;
  // A write-back with nothing outstanding is a protocol error and never decrements.
  assign wb_dec_s = wb_valid & (outstanding_q != {AW{1'b0}});
  assign err_d    = err_q | (wb_valid & (outstanding_q == {AW{1'b0}}));

  // Outstanding butterfly counter: +1 on accept, -1 on legal write-back.
  always_comb begin
    outstanding_d = outstanding_q;
    case ({accept_s, wb_dec_s})
      2'b10:   outstanding_d = outstanding_q + A_ONE;
      2'b01:   outstanding_d = outstanding_q - A_ONE;
      default: outstanding_d = outstanding_q;
    endcase
  end

  // Sequencer FSM: butterfly index, stage and the stage barrier.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    stage_d = stage_q;
    valid_d = valid_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_ISSUE;
          k_d     = {KW{1'b0}};
          stage_d = {SW{1'b0}};
          valid_d = 1'b1;
        end else begin
          valid_d = 1'b0;
        end
      end
      S_ISSUE: begin
        if (accept_s) begin
          if (k_q == K_LAST) begin
            state_d = S_DRAIN;
            valid_d = 1'b0;
          end else begin
            k_d = k_q + K_ONE;
          end
        end else begin
          valid_d = 1'b1;
        end
      end
      S_DRAIN: begin
        // Leave as soon as the last write-back lands, so the next stage
        // issues in the cycle right after it.
        if (outstanding_d == {AW{1'b0}}) begin
          k_d = {KW{1'b0}};
          if (stage_q == STAGE_LAST) begin
            state_d = S_IDLE;
            stage_d = {SW{1'b0}};
            done_d  = 1'b1;
          end else begin
            state_d = S_ISSUE;
            stage_d = stage_q + S_ONE;
            valid_d = 1'b1;
          end
        end else begin
          valid_d = 1'b0;
        end
      end
      default: begin
        state_d = S_IDLE;
        k_d     = {KW{1'b0}};
        stage_d = {SW{1'b0}};
        valid_d = 1'b0;
      end
    endcase
  end

  // Address and twiddle for the next butterfly; zero whenever idle.
  always_comb begin
    k_ext_s = {1'b0, k_d};
    half_s  = A_ONE << stage_d;
    mask_s  = half_s - A_ONE;
    pos_s   = k_ext_s & mask_s;
    a_s     = ((k_ext_s & ~mask_s) << 1) | pos_s;
    b_s     = a_s | half_s;
    t_s     = pos_s[KW-1:0] << (STAGE_LAST - stage_d);
    busy_d  = (state_d != S_IDLE);
    if (state_d != S_IDLE) begin
      addr_a_d = a_s;
      addr_b_d = b_s;
      tw_d     = t_s;
    end else begin
      addr_a_d = {AW{1'b0}};
      addr_b_d = {AW{1'b0}};
      tw_d     = {KW{1'b0}};
    end
`ifdef FFT_BFLY_SCALE_EN
    scale_d = valid_d;
`else
    scale_d = 1'b0;
`endif
  end

  // State and output registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      k_q           <= {KW{1'b0}};
      stage_q       <= {SW{1'b0}};
      outstanding_q <= {AW{1'b0}};
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      valid_q       <= 1'b0;
      scale_q       <= 1'b0;
      err_q         <= 1'b0;
      addr_a_q      <= {AW{1'b0}};
      addr_b_q      <= {AW{1'b0}};
      tw_q          <= {KW{1'b0}};
    end else begin
      state_q       <= state_d;
      k_q           <= k_d;
      stage_q       <= stage_d;
      outstanding_q <= outstanding_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      valid_q       <= valid_d;
      scale_q       <= scale_d;
      err_q         <= err_d;
      addr_a_q      <= addr_a_d;
      addr_b_q      <= addr_b_d;
      tw_q          <= tw_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign bf_valid = valid_q;
  assign bf_scale = scale_q;
  assign err      = err_q;
  assign addr_a   = addr_a_q;
  assign addr_b   = addr_b_q;
  assign tw_idx   = tw_q;
  assign stage    = stage_q;

endmodule

// File: tb/tb_fft_bfly_scheduler.sv
// Self-checking bench for fft_bfly_scheduler (N_LOG2=3) using a transaction
// level reference model: butterfly table built by enumerating pairs per stage,
// and a barrier rule "butterfly i may issue once all earlier stages wrote back".
module tb_fft_bfly_scheduler;
  localparam int N_LOG2 = 3;
  localparam int N      = 8;
  localparam int HALF_N = 4;
  localparam int TOTAL  = 12;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic start = 1'b0;
  logic bf_ready = 1'b0;
  logic wb_valid = 1'b0;
  logic busy, done, bf_valid, bf_scale, err;
  logic [2:0] addr_a, addr_b;
  logic [1:0] tw_idx, stage;

  fft_bfly_scheduler #(.N_LOG2(N_LOG2)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .bf_valid(bf_valid), .bf_ready(bf_ready), .addr_a(addr_a), .addr_b(addr_b),
    .tw_idx(tw_idx), .stage(stage), .bf_scale(bf_scale), .wb_valid(wb_valid),
    .err(err)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  bit m_run, m_done, m_valid, m_err;
  int m_idx, m_wbs, m_out;
  int tab_a[TOTAL], tab_b[TOTAL], tab_tw[TOTAL], tab_s[TOTAL];
  int wbq[$];
  int log_a[$], log_b[$], log_tw[$];
  int ready_pct = 100, wb_dmin = 2, wb_dmax = 2, stall_left = 0;
  int done_cnt = 0, dut_acc = 0, wb4_cyc = -1;
  bit wb_hold = 1'b0, inject_wb = 1'b0;

  int lit_a[12]  = '{0, 2, 4, 6, 0, 1, 4, 5, 0, 1, 2, 3};
  int lit_b[12]  = '{1, 3, 5, 7, 2, 3, 6, 7, 4, 5, 6, 7};
  int lit_tw[12] = '{0, 0, 0, 0, 0, 2, 0, 2, 0, 1, 2, 3};

  task automatic build_table();
    int n = 0;
    for (int s = 0; s < N_LOG2; s++) begin
      int half = 1 << s;
      for (int i = 0; i < N; i++) begin
        if ((i & half) == 0) begin
          tab_a[n]  = i;
          tab_b[n]  = i + half;
          tab_tw[n] = (i % half) * (N / (2 * half));
          tab_s[n]  = s;
          n++;
        end
      end
    end
  endtask

  task automatic model_reset();
    m_run = 0; m_done = 0; m_valid = 0; m_err = 0;
    m_idx = 0; m_wbs = 0; m_out = 0;
    wbq.delete();
  endtask

  function automatic logic [14:0] obs_vec();
    return {busy, done, bf_valid, bf_scale, err, stage, addr_a, addr_b, tw_idx};
  endfunction

  function automatic logic [14:0] exp_vec();
    logic [14:0] v;
    logic sc;
`ifdef FFT_BFLY_SCALE_EN
    sc = m_valid;
`else
    sc = 1'b0;
`endif
    v = {m_run, m_done, m_valid, sc, m_err, 10'd0};
    if (m_valid)
      v[9:0] = {2'(tab_s[m_idx]), 3'(tab_a[m_idx]), 3'(tab_b[m_idx]), 2'(tab_tw[m_idx])};
    return v;
  endfunction

  // While draining, the address/stage fields are not constrained.
  function automatic logic [14:0] exp_mask();
    if (m_run && !m_valid) return 15'h7C00;
    return 15'h7FFF;
  endfunction

  // Drive one cycle of inputs, cross the clock edge and advance the model.
  task automatic tick();
    bit acc, wb, st;
    if (stall_left > 0) begin
      bf_ready = 1'b0;
      stall_left--;
    end else begin
      bf_ready = ($urandom_range(99) < ready_pct);
    end
    wb_valid = 1'b0;
    if (inject_wb) begin
      wb_valid = 1'b1;
      inject_wb = 1'b0;
    end else if (!wb_hold && wbq.size() > 0 && wbq[0] <= cyc) begin
      wb_valid = 1'b1;
      void'(wbq.pop_front());
    end
    acc = m_valid && bf_ready;
    wb  = wb_valid;
    st  = start;
    if (bf_valid && bf_ready) begin
      dut_acc++;
      log_a.push_back(int'(addr_a));
      log_b.push_back(int'(addr_b));
      log_tw.push_back(int'(tw_idx));
    end
    @(posedge clk);
    #1;
    cyc++;
    start = 1'b0;
    m_done = 0;
    if (wb) begin
      if (m_out == 0) m_err = 1;
      else begin
        m_out--;
        m_wbs++;
        if (m_wbs == HALF_N) wb4_cyc = cyc;
      end
    end
    if (acc) begin
      m_out++;
      m_idx++;
      wbq.push_back(cyc + int'($urandom_range(wb_dmax, wb_dmin)) - 1);
    end
    if (m_run && m_idx == TOTAL && m_wbs == TOTAL) begin
      m_run = 0;
      m_done = 1;
    end else if (!m_run && st) begin
      m_run = 1; m_idx = 0; m_wbs = 0;
    end
    m_valid = m_run && (m_idx < TOTAL) && (m_wbs >= (m_idx / HALF_N) * HALF_N);
    if (done) done_cnt++;
  endtask

  task automatic clear_logs();
    log_a.delete(); log_b.delete(); log_tw.delete();
    dut_acc = 0; done_cnt = 0;
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #10;
    if (obs_vec() !== 15'd0) begin
      miscompares++;
      $display("FAIL reset_state got=%h exp=%h", obs_vec(), 15'd0);
    end
    vectors++;
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      tick();
      if ((obs_vec() & exp_mask()) !== (exp_vec() & exp_mask())) begin
        miscompares++;
        $display("FAIL reset_idle cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_vec());
      end
      vectors++;
    end
  endtask

  task automatic test_nominal();
    int g = 0;
    ready_pct = 100; wb_dmin = 2; wb_dmax = 2;
    clear_logs();
    start = 1'b1;
    do begin
      tick();
      g++;
      if ((obs_vec() & exp_mask()) !== (exp_vec() & exp_mask())) begin
        miscompares++;
        $display("FAIL nominal cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_vec());
      end
      vectors++;
    end while (m_run && g < 300);
    if (m_run) begin miscompares++; $display("FAIL nominal_timeout got=running exp=idle"); end
    vectors++;
    if (dut_acc != TOTAL || done_cnt != 1) begin
      miscompares++;
      $display("FAIL nominal_counts accepts=%0d done=%0d exp=12/1", dut_acc, done_cnt);
    end
    vectors++;
    for (int i = 0; i < TOTAL && i < log_a.size(); i++) begin
      if (log_a[i] != lit_a[i] || log_b[i] != lit_b[i] || log_tw[i] != lit_tw[i]) begin
        miscompares++;
        $display("FAIL nominal_seq #%0d got=(%0d,%0d) tw%0d exp=(%0d,%0d) tw%0d",
                 i, log_a[i], log_b[i], log_tw[i], lit_a[i], lit_b[i], lit_tw[i]);
      end
      vectors++;
    end
  endtask

  task automatic test_stall();
    int g = 0;
    bit stalled = 0;
    ready_pct = 100; wb_dmin = 2; wb_dmax = 2;
    clear_logs();
    start = 1'b1;
    do begin
      if (m_valid && m_idx == 5 && !stalled) begin
        stall_left = 3;
        stalled = 1;
      end
      tick();
      g++;
      if ((obs_vec() & exp_mask()) !== (exp_vec() & exp_mask())) begin
        miscompares++;
        $display("FAIL stall cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_vec());
      end
      vectors++;
      if (bf_ready === 1'b0 && stalled) begin
        if ({bf_valid, stage, addr_a, addr_b, tw_idx} !== {1'b1, 2'd1, 3'd1, 3'd3, 2'd2}) begin
          miscompares++;
          $display("FAIL stall_hold cyc=%0d got=%h exp=%h", cyc,
                   {bf_valid, stage, addr_a, addr_b, tw_idx}, {1'b1, 2'd1, 3'd1, 3'd3, 2'd2});
        end
        vectors++;
      end
    end while (m_run && g < 300);
    if (!stalled || dut_acc != TOTAL || done_cnt != 1) begin
      miscompares++;
      $display("FAIL stall_counts accepts=%0d done=%0d exp=12/1", dut_acc, done_cnt);
    end
    vectors++;
    for (int i = 0; i < TOTAL && i < log_a.size(); i++) begin
      if (log_a[i] != lit_a[i] || log_b[i] != lit_b[i] || log_tw[i] != lit_tw[i]) begin
        miscompares++;
        $display("FAIL stall_seq #%0d got=(%0d,%0d) tw%0d exp=(%0d,%0d) tw%0d",
                 i, log_a[i], log_b[i], log_tw[i], lit_a[i], lit_b[i], lit_tw[i]);
      end
      vectors++;
    end
  endtask

  task automatic test_barrier();
    int g = 0, held = 0, v1_cyc = -1;
    ready_pct = 100; wb_dmin = 2; wb_dmax = 2;
    clear_logs();
    wb4_cyc = -1;
    wb_hold = 1'b1;
    start = 1'b1;
    do begin
      if (m_idx >= HALF_N && wb_hold) begin
        held++;
        if (held > 10) wb_hold = 1'b0;
      end
      tick();
      g++;
      if ((obs_vec() & exp_mask()) !== (exp_vec() & exp_mask())) begin
        miscompares++;
        $display("FAIL barrier cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_vec());
      end
      vectors++;
      if (v1_cyc < 0 && bf_valid === 1'b1 && stage === 2'd1) v1_cyc = cyc;
    end while (m_run && g < 300);
    wb_hold = 1'b0;
    if (v1_cyc != wb4_cyc || wb4_cyc < 0) begin
      miscompares++;
      $display("FAIL barrier_release stage1_issue_cyc=%0d exp=%0d", v1_cyc, wb4_cyc);
    end
    vectors++;
  endtask

  task automatic test_back_to_back();
    int g = 0;
    ready_pct = 100; wb_dmin = 2; wb_dmax = 2;
    clear_logs();
    start = 1'b1;
    do begin
      if (g == 3 || g == 9 || g == 15) start = 1'b1;
      tick();
      g++;
      if ((obs_vec() & exp_mask()) !== (exp_vec() & exp_mask())) begin
        miscompares++;
        $display("FAIL b2b cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_vec());
      end
      vectors++;
    end while (m_run && g < 300);
    if (dut_acc != TOTAL || done_cnt != 1) begin
      miscompares++;
      $display("FAIL b2b_counts accepts=%0d done=%0d exp=12/1", dut_acc, done_cnt);
    end
    vectors++;
    tick();
    start = 1'b1;
    tick();
    if ({busy, bf_valid} !== 2'b11) begin
      miscompares++;
      $display("FAIL b2b_restart got=%b exp=11", {busy, bf_valid});
    end
    vectors++;
    g = 0;
    while (m_run && g < 300) begin
      tick();
      g++;
      if ((obs_vec() & exp_mask()) !== (exp_vec() & exp_mask())) begin
        miscompares++;
        $display("FAIL b2b_rerun cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_vec());
      end
      vectors++;
    end
  endtask

  task automatic test_reset_mid();
    int g = 0;
    ready_pct = 100; wb_dmin = 2; wb_dmax = 2;
    start = 1'b1;
    do begin
      tick();
      g++;
    end while (m_idx < 5 && g < 100);
    #2 rst_n = 1'b0;
    wb_valid = 1'b0;
    #1;
    if (obs_vec() !== 15'd0) begin
      miscompares++;
      $display("FAIL reset_async got=%h exp=%h", obs_vec(), 15'd0);
    end
    vectors++;
    @(posedge clk); #1;
    cyc++;
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 5; i++) begin
      tick();
      if ((obs_vec() & exp_mask()) !== (exp_vec() & exp_mask())) begin
        miscompares++;
        $display("FAIL reset_stay_idle cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_vec());
      end
      vectors++;
    end
  endtask

  task automatic test_spurious_wb();
    inject_wb = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      if ((obs_vec() & exp_mask()) !== (exp_vec() & exp_mask())) begin
        miscompares++;
        $display("FAIL spurious_wb cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_vec());
      end
      vectors++;
    end
    #2 rst_n = 1'b0;
    #1;
    if (err !== 1'b0) begin
      miscompares++;
      $display("FAIL err_clear got=%b exp=0", err);
    end
    vectors++;
    @(posedge clk); #1;
    cyc++;
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_random();
    int g;
    ready_pct = 60; wb_dmin = 1; wb_dmax = 5;
    for (int r = 0; r < 3; r++) begin
      clear_logs();
      for (int i = 0; i < int'($urandom_range(3, 0)); i++) tick();
      start = 1'b1;
      g = 0;
      do begin
        tick();
        g++;
        if ((obs_vec() & exp_mask()) !== (exp_vec() & exp_mask())) begin
          miscompares++;
          $display("FAIL random cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_vec());
        end
        vectors++;
      end while (m_run && g < 600);
      if (m_run || dut_acc != TOTAL || done_cnt != 1) begin
        miscompares++;
        $display("FAIL random_counts run=%0d accepts=%0d done=%0d exp=12/1", r, dut_acc, done_cnt);
      end
      vectors++;
    end
  endtask

  initial begin
    build_table();
    model_reset();
    test_reset();
    test_nominal();
    test_stall();
    test_barrier();
    test_back_to_back();
    test_reset_mid();
    test_spurious_wb();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
